// File: rtl/rs_enc_arbiter.sv
// Two-channel round-robin arbiter in front of one rs_encoder. It grants a channel for a whole
// codeword and re-arbitrates only after the codeword's final parity symbol has been consumed.
module rs_enc_arbiter #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned N           = 15,
    parameter int unsigned K           = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_valid,
    input  logic [1:0]               i_start_codeword,
    input  logic [1:0]               i_end_codeword,
    input  logic [2*WORD_LENGTH-1:0] i_symbol,
    output logic [1:0]               o_in_ready,
    output logic                     o_enc_valid,
    output logic                     o_enc_start_codeword,
    output logic                     o_enc_end_codeword,
    output logic [WORD_LENGTH-1:0]   o_enc_symbol,
    input  logic                     i_enc_in_ready,
    input  logic                     i_enc_end_codeword,
    input  logic                     i_enc_error,
    input  logic                     i_consume,
    output logic                     o_channel,
    output logic                     o_busy,
    output logic                     o_drop,
    output logic                     o_error
);

    localparam int unsigned CntW = $clog2(K + 1);

    if (N <= K) begin : g_param_check
        $error("rs_enc_arbiter: N must exceed K");
    end

    typedef enum logic [1:0] {StIdle, StForward, StDrain, StError} state_e;

    state_e                 r_state;
    logic                   r_grant;
    logic                   r_last;
    logic [CntW-1:0]        r_sym_cnt;

    logic [1:0]             req;
    logic [1:0]             orphan;
    logic                   grant_c;
    logic                   accept;
    logic [WORD_LENGTH-1:0] sym_g;

    assign req     = i_valid & i_start_codeword;
    assign orphan  = i_valid & ~i_start_codeword;
    // On a tie the channel that did not win last time gets the grant.
    assign grant_c = (req == 2'b11) ? ~r_last : req[1];
    assign sym_g   = r_grant ? i_symbol[2*WORD_LENGTH-1 -: WORD_LENGTH]
                             : i_symbol[WORD_LENGTH-1:0];
    assign accept  = i_valid[r_grant] & i_enc_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_sym_cnt <= '0;
        end else if (i_enc_error) begin
            r_state <= StError;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|req) begin
                        r_grant   <= grant_c;
                        r_last    <= grant_c;
                        r_sym_cnt <= '0;
                        r_state   <= StForward;
                    end
                end
                StForward: begin
                    if (accept) begin
                        if (r_sym_cnt != CntW'(K)) begin
                            r_sym_cnt <= r_sym_cnt + 1'b1;
                        end
                        if (i_end_codeword[r_grant]) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (i_enc_end_codeword && i_consume) begin
                        r_state <= StIdle;
                    end
                end
                StError: r_state <= StError;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_in_ready           = 2'b00;
        o_enc_valid          = 1'b0;
        o_enc_start_codeword = 1'b0;
        o_enc_end_codeword   = 1'b0;
        o_enc_symbol         = '0;
        o_drop               = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Symbols arriving without a start marker are swallowed here.
                o_in_ready = orphan;
                o_drop     = |orphan;
            end
            StForward: begin
                o_enc_valid          = i_valid[r_grant];
                o_enc_start_codeword = i_start_codeword[r_grant];
                o_enc_end_codeword   = i_end_codeword[r_grant];
                o_enc_symbol         = sym_g;
                o_in_ready[r_grant]  = i_enc_in_ready;
            end
            default: ;
        endcase
    end

    assign o_channel = r_grant;
    assign o_busy    = (r_state == StForward) || (r_state == StDrain);
    assign o_error   = (r_state == StError);

endmodule

// File: tb/tb_rs_enc_arbiter.sv
// Self-checking bench for rs_enc_arbiter: IDLE vector table, scoreboard on the encoder side,
// and hand sequences for reset, round-robin, stall, backpressure, single-symbol and error.
module tb_rs_enc_arbiter;

    localparam int W = 8;
    localparam int N = 15;
    localparam int K = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     i_valid, i_start_codeword, i_end_codeword, o_in_ready;
    logic [2*W-1:0] i_symbol;
    logic           o_enc_valid, o_enc_start_codeword, o_enc_end_codeword;
    logic [W-1:0]   o_enc_symbol;
    logic           i_enc_in_ready, i_enc_end_codeword, i_enc_error, i_consume;
    logic           o_channel, o_busy, o_drop, o_error;

    int checks   = 0;
    int failures = 0;
    logic last_g = 1'b1;

    typedef struct packed {
        logic         ch;
        logic [W-1:0] sym;
        logic         st;
        logic         en;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct packed {
        logic [1:0]     valid;
        logic [1:0]     start;
        logic [2*W-1:0] sym;
        logic [1:0]     exp_ready;
        logic           exp_drop;
    } idle_vec_t;

    always #5 clk = ~clk;

    rs_enc_arbiter #(.WORD_LENGTH(W), .N(N), .K(K)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_valid             (i_valid),
        .i_start_codeword    (i_start_codeword),
        .i_end_codeword      (i_end_codeword),
        .i_symbol            (i_symbol),
        .o_in_ready          (o_in_ready),
        .o_enc_valid         (o_enc_valid),
        .o_enc_start_codeword(o_enc_start_codeword),
        .o_enc_end_codeword  (o_enc_end_codeword),
        .o_enc_symbol        (o_enc_symbol),
        .i_enc_in_ready      (i_enc_in_ready),
        .i_enc_end_codeword  (i_enc_end_codeword),
        .i_enc_error         (i_enc_error),
        .i_consume           (i_consume),
        .o_channel           (o_channel),
        .o_busy              (o_busy),
        .o_drop              (o_drop),
        .o_error             (o_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder-side scoreboard: every transfer the encoder accepts must match the next entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && o_enc_valid && i_enc_in_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got symbol %0h expected none", o_enc_symbol);
            end else begin
                e = sb.pop_front();
                check("sb_symbol", 32'(o_enc_symbol), 32'(e.sym));
                check("sb_channel", 32'(o_channel), 32'(e.ch));
                check("sb_start", 32'(o_enc_start_codeword), 32'(e.st));
                check("sb_end", 32'(o_enc_end_codeword), 32'(e.en));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] sym_of(input int c, input int i);
        return 8'(c * 8'h40 + i * 8'h05 + 8'h11);
    endfunction

    function automatic int pick(input logic [1:0] req);
        if (req == 2'b11) return last_g ? 0 : 1;
        return req[1] ? 1 : 0;
    endfunction

    task automatic drive_ch(input int c, input logic v, input logic st, input logic en,
                            input logic [W-1:0] s);
        i_valid[c]          = v;
        i_start_codeword[c] = st;
        i_end_codeword[c]   = en;
        i_symbol[c*W +: W]  = s;
    endtask

    task automatic clear_inputs();
        i_valid = '0; i_start_codeword = '0; i_end_codeword = '0; i_symbol = '0;
        i_enc_in_ready = 1'b1; i_enc_end_codeword = 1'b0; i_enc_error = 1'b0; i_consume = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE just after a posedge; returns in IDLE just after the DRAIN-exit edge.
    task automatic run_cw(input int c, input int nsym, input bit other_req, input int stall_at,
                          input int bp_cycles);
        int o;
        logic [1:0] want;
        o    = 1 - c;
        want = (c == 0) ? 2'b01 : 2'b10;
        drive_ch(c, 1'b1, 1'b1, nsym == 1, sym_of(c, 0));
        if (other_req) drive_ch(o, 1'b1, 1'b1, 1'b0, sym_of(o, 0));
        else           drive_ch(o, 1'b0, 1'b0, 1'b0, '0);
        i_enc_in_ready = 1'b1; i_enc_end_codeword = 1'b0; i_consume = 1'b0;
        mid();
        check("idle_busy", 32'(o_busy), 0);
        check("idle_in_ready", 32'(o_in_ready), 0);
        check("idle_enc_valid", 32'(o_enc_valid), 0);
        step();
        for (int i = 0; i < nsym; i++) begin
            drive_ch(c, 1'b1, i == 0, i == nsym - 1, sym_of(c, i));
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    i_enc_in_ready = 1'b0;
                    mid();
                    check("stall_in_ready", 32'(o_in_ready), 0);
                    check("stall_busy", 32'(o_busy), 1);
                    step();
                end
                i_enc_in_ready = 1'b1;
            end
            sb.push_back('{c[0], sym_of(c, i), i == 0, i == nsym - 1});
            mid();
            check("fwd_in_ready", 32'(o_in_ready), 32'(want));
            check("fwd_channel", 32'(o_channel), 32'(c));
            check("fwd_busy", 32'(o_busy), 1);
            step();
        end
        drive_ch(c, 1'b0, 1'b0, 1'b0, '0);
        for (int b = 0; b < bp_cycles; b++) begin
            i_enc_end_codeword = 1'b1; i_consume = 1'b0;
            mid();
            check("drain_busy", 32'(o_busy), 1);
            check("drain_in_ready", 32'(o_in_ready), 0);
            check("drain_enc_valid", 32'(o_enc_valid), 0);
            step();
        end
        i_enc_end_codeword = 1'b1; i_consume = 1'b1;
        mid();
        check("drain_exit_busy", 32'(o_busy), 1);
        step();
        i_enc_end_codeword = 1'b0; i_consume = 1'b0;
    endtask

    idle_vec_t idle_tbl[7];
    int g;

    initial begin
        idle_tbl[0] = '{2'b00, 2'b00, 16'h0000, 2'b00, 1'b0};
        idle_tbl[1] = '{2'b10, 2'b00, 16'hA500, 2'b10, 1'b1};
        idle_tbl[2] = '{2'b01, 2'b00, 16'h003C, 2'b01, 1'b1};
        idle_tbl[3] = '{2'b11, 2'b00, 16'h1234, 2'b11, 1'b1};
        idle_tbl[4] = '{2'b11, 2'b11, 16'h5678, 2'b00, 1'b0};
        idle_tbl[5] = '{2'b10, 2'b01, 16'h9ABC, 2'b10, 1'b1};
        idle_tbl[6] = '{2'b01, 2'b10, 16'hDEF0, 2'b01, 1'b1};

        // Reset with both channels requesting.
        clear_inputs();
        rst = 1'b0;
        drive_ch(0, 1'b1, 1'b1, 1'b0, sym_of(0, 0));
        drive_ch(1, 1'b1, 1'b1, 1'b0, sym_of(1, 0));
        mid();
        mid();
        check("rst_in_ready", 32'(o_in_ready), 0);
        check("rst_enc_valid", 32'(o_enc_valid), 0);
        check("rst_enc_symbol", 32'(o_enc_symbol), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_drop", 32'(o_drop), 0);
        check("rst_error", 32'(o_error), 0);
        check("rst_channel", 32'(o_channel), 0);
        step();
        rst = 1'b1;

        // Round-robin over four codewords, with a stall and downstream backpressure.
        for (int n = 0; n < 4; n++) begin
            g = pick(2'b11);
            last_g = g[0];
            run_cw(g, K, 1'b1, (n == 2) ? 4 : -1, (n == 3) ? 3 : 0);
        end
        clear_inputs();

        // IDLE combinational table; inputs are withdrawn before the next edge.
        foreach (idle_tbl[i]) begin
            i_valid = idle_tbl[i].valid;
            i_start_codeword = idle_tbl[i].start;
            i_symbol = idle_tbl[i].sym;
            mid();
            check("tbl_in_ready", 32'(o_in_ready), 32'(idle_tbl[i].exp_ready));
            check("tbl_drop", 32'(o_drop), 32'(idle_tbl[i].exp_drop));
            check("tbl_enc_valid", 32'(o_enc_valid), 0);
            check("tbl_busy", 32'(o_busy), 0);
            #1 clear_inputs();
            step();
        end

        // Orphan drop held across an edge: one pulse, no grant.
        drive_ch(1, 1'b1, 1'b0, 1'b0, 8'hA5);
        mid();
        check("orphan_in_ready", 32'(o_in_ready), 32'h2);
        check("orphan_drop", 32'(o_drop), 1);
        step();
        clear_inputs();
        mid();
        check("orphan_drop_after", 32'(o_drop), 0);
        check("orphan_no_grant", 32'(o_busy), 0);
        step();

        // Single-symbol codeword from ch1 alone.
        g = pick(2'b10);
        last_g = g[0];
        run_cw(g, 1, 1'b0, -1, 1);
        clear_inputs();

        // Error during FORWARD.
        drive_ch(0, 1'b1, 1'b1, 1'b0, sym_of(0, 0));
        step();
        for (int i = 0; i < 4; i++) begin
            drive_ch(0, 1'b1, i == 0, 1'b0, sym_of(0, i));
            i_enc_error = (i == 3);
            sb.push_back('{1'b0, sym_of(0, i), i == 0, 1'b0});
            step();
        end
        i_enc_error = 1'b0;
        drive_ch(0, 1'b1, 1'b1, 1'b0, sym_of(0, 0));
        drive_ch(1, 1'b1, 1'b1, 1'b0, sym_of(1, 0));
        for (int i = 0; i < 3; i++) begin
            mid();
            check("err_error", 32'(o_error), 1);
            check("err_in_ready", 32'(o_in_ready), 0);
            check("err_busy", 32'(o_busy), 0);
            check("err_enc_valid", 32'(o_enc_valid), 0);
            check("err_channel", 32'(o_channel), 0);
            step();
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        check("err_cleared", 32'(o_error), 0);
        check("err_rst_busy", 32'(o_busy), 0);
        step();
        rst = 1'b1;
        mid();
        check("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_enc_arbiter.md
# rs_enc_arbiter

Two-channel, codeword-granular round-robin arbiter that shares one `rs_encoder` between two independent symbol sources. It sits directly in front of the encoder's input handshake. It grants one channel for a whole codeword, holds the grant until the encoder has emitted and delivered that codeword's final parity symbol, and then re-arbitrates. It also tags the encoder output with the owning channel and latches encoder errors.

## Interface
- `WORD_LENGTH`, 8, symbol width in bits
- `N`, 15, codeword length; must match the encoder
- `K`, 11, message length; must match the encoder

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_valid`  in  2  per-channel symbol valid (bit c = channel c)
- `i_start_codeword`  in  2  per-channel first-symbol marker
- `i_end_codeword`  in  2  per-channel last-message-symbol marker
- `i_symbol`  in  2*WORD_LENGTH  channel c occupies bits [c*WORD_LENGTH +: WORD_LENGTH]
- `o_in_ready`  out  2  per-channel accept
- `o_enc_valid`, `o_enc_start_codeword`, `o_enc_end_codeword`  out  1 each  to encoder inputs
- `o_enc_symbol`  out  WORD_LENGTH  to encoder `i_symbol`
- `i_enc_in_ready`  in  1  encoder `o_in_ready`
- `i_enc_end_codeword`  in  1  encoder `o_end_codeword`
- `i_enc_error`  in  1  encoder `o_error`
- `i_consume`  in  1  downstream consume; also drives encoder `i_consume` externally
- `o_channel`  out  1  owner of the codeword currently in the encoder
- `o_busy`  out  1  high in FORWARD and DRAIN
- `o_drop`  out  1  one-cycle pulse when an orphan symbol is discarded
- `o_error`  out  1  sticky error

## Operation
- States: IDLE, FORWARD, DRAIN, ERROR. Registers: `r_state`, `r_grant` (1 bit), `r_last` (1 bit), `r_sym_cnt` (ceil(log2(K+1)) bits).
- Request: `req[c] = i_valid[c] && i_start_codeword[c]`.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that channel.
  - Both request: grant `!r_last`.
  - On grant: `r_grant <= c`, `r_last <= c`, `r_sym_cnt <= 0`, go to FORWARD. The start symbol is not consumed in IDLE.
  - Orphan symbols: `o_in_ready[c] = i_valid[c] && !i_start_codeword[c]`. Each such symbol is dropped and `o_drop` pulses. If both channels drop in the same cycle, `o_drop` is a single pulse.
  - All `o_enc_*` outputs are 0.
- **FORWARD** (combinational pass-through of granted channel g)
  - `o_enc_valid = i_valid[g]`; start, end and symbol are muxed from channel g.
  - `o_in_ready[g] = i_enc_in_ready`; `o_in_ready[!g] = 0`.
  - Accept is `i_valid[g] && i_enc_in_ready`. Each accept increments `r_sym_cnt`, saturating at K.
  - Accept with `i_end_codeword[g]`: go to DRAIN.
- **DRAIN**
  - `o_in_ready = 0`; all `o_enc_*` outputs are 0.
  - `i_enc_end_codeword && i_consume`: go to IDLE.
- **ERROR**
  - Entered from any state on `i_enc_error`; this has priority over every other transition.
  - All outputs except `o_error` and `o_channel` are 0. `o_error = 1` until reset.
- Protocol violations (start mid-codeword, more than K symbols) are passed to the encoder unmodified; the arbiter reacts only through `i_enc_error`.
- `o_channel = r_grant`. It is meaningful while `o_busy` is high and holds its last value otherwise.

## Timing
- Reset values:
  - `r_state` = IDLE, `r_grant` = 0, `r_last` = 1 (channel 0 wins the first tie), `r_sym_cnt` = 0.
  - All outputs 0.
- Reset asserted mid-codeword returns the block to IDLE immediately (asynchronous). No partial state survives.
- Grant latency: a request sampled in IDLE at edge T puts the block in FORWARD after T. The start symbol can be accepted in the cycle after T.
- Forwarding adds zero latency. Combinational paths run from `i_*` and `i_enc_in_ready` to `o_enc_*` and `o_in_ready`.
- DRAIN exits at the edge that samples `i_enc_end_codeword && i_consume`. IDLE is active the following cycle.
  - Minimum gap between codewords from different channels: DRAIN exit, plus 1 IDLE cycle, plus the start accept.
- Requests seen during FORWARD or DRAIN are not recorded. They are re-evaluated in IDLE from the live inputs.
- `i_enc_error` and a state-exit condition in the same cycle: ERROR wins.
- Single-symbol codeword (start and end together on one accept): FORWARD goes to DRAIN after one cycle.

## Test plan
- **Reset.** Assert reset, then release it with ch0 and ch1 both requesting. Required:
  - All outputs are 0 during reset.
  - ch0 is granted first; `o_channel` = 0.
  - 11 symbols are forwarded with `o_in_ready` = 2'b01.
- **Round-robin.** Both channels request continuously for 4 codewords. Required: grant order 0,1,0,1 and `o_channel` toggles. Each new grant occurs 1 cycle after `i_enc_end_codeword && i_consume`.
- **Stall.** Hold `i_enc_in_ready` = 0 for 3 cycles mid-codeword. Required: `o_in_ready[g]` = 0, no counter increment and no state change. After release, the remaining symbols pass in order.
- **Orphan drop.** In IDLE, drive ch1 `i_valid` = 1 with `i_start_codeword` = 0 and symbol 0xA5. Required: `o_in_ready` = 2'b10, `o_drop` pulses once, no grant.
- **Downstream backpressure.** Hold `i_consume` low while the encoder asserts `i_enc_end_codeword`. Required: the block stays in DRAIN and `o_busy` = 1. Re-arbitration happens only after `i_consume` rises.
- **Error.** Pulse `i_enc_error` in FORWARD. Required: the block enters ERROR on the next edge and `o_error` stays 1. `o_in_ready` stays 0 despite requests until reset is asserted.
